// File: rtl/led_target_ctrl.sv
// led_target_ctrl: lights requested targets for a level-dependent lifetime, scores hits, counts misses, ends the game.
// Optional `TARGET_PENALTY_EN: wrong hits also add to misses.
module led_target_ctrl #(
    parameter int LED_COUNT  = 18,
    parameter int IDX_W      = $clog2(LED_COUNT),
    parameter int LIFE0      = 50_000_000,
    parameter int LIFE1      = 20_000_000,
    parameter int LIFE2      = 10_000_000,
    parameter int MAX_MISSES = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           level,
    input  logic                 led_request,
    input  logic [IDX_W-1:0]     led_index,
    input  logic                 hit_valid,
    input  logic [IDX_W-1:0]     hit_index,
    output logic [LED_COUNT-1:0] leds,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 wrong_pulse,
    output logic [15:0]          score,
    output logic [7:0]           misses,
    output logic                 game_over
);
    typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
    state_t                      r_state;
    logic [LED_COUNT-1:0][31:0]  r_life;
    logic [LED_COUNT-1:0]        w_req_sel, w_hit_sel, w_expire, w_set;
    logic                        w_hit_ok, w_wrong;
    logic [31:0]                 w_load;
    logic [9:0]                  w_add, w_sum;
    logic [7:0]                  w_misses_nx;

    always_comb begin
        w_load = (level == 2'd1) ? 32'(LIFE1) : (level == 2'd2) ? 32'(LIFE2) : 32'(LIFE0);
        w_hit_sel = '0;
        w_req_sel = '0;
        w_expire = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            w_hit_sel[i] = hit_valid && hit_index == IDX_W'(i);
            w_req_sel[i] = led_request && led_index == IDX_W'(i);
        end
        w_hit_ok = |(w_hit_sel & leds);
        w_wrong = hit_valid && !w_hit_ok;
        w_set = w_req_sel & ~leds;
        // a hit landing on the final lifetime cycle wins over the expiry
        for (int i = 0; i < LED_COUNT; i++)
            w_expire[i] = leds[i] && r_life[i] == 32'd1 && !w_hit_sel[i];
`ifdef TARGET_PENALTY_EN
        w_add = 10'(w_wrong);
`else
        w_add = '0;
`endif
        for (int i = 0; i < LED_COUNT; i++)
            w_add = w_add + 10'(w_expire[i]);
        w_sum = 10'(misses) + w_add;
        w_misses_nx = (w_sum >= 10'(MAX_MISSES)) ? 8'(MAX_MISSES) : w_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_life      <= '0;
            leds        <= '0;
            score       <= '0;
            misses      <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            wrong_pulse <= 1'b0;
            if (start) begin
                r_state   <= RUN;
                r_life    <= '0;
                leds      <= '0;
                score     <= '0;
                misses    <= '0;
                game_over <= 1'b0;
            end else if (r_state == RUN && misses >= 8'(MAX_MISSES)) begin
                r_state   <= OVER;
                r_life    <= '0;
                leds      <= '0;
                game_over <= 1'b1;
            end else if (r_state == RUN) begin
                for (int i = 0; i < LED_COUNT; i++)
                    r_life[i] <= w_set[i] ? w_load : leds[i] ? r_life[i] - 32'd1 : r_life[i];
                leds        <= w_set | (leds & ~w_hit_sel & ~w_expire);
                score       <= score + 16'(w_hit_ok && score != 16'hFFFF);
                misses      <= w_misses_nx;
                hit_pulse   <= w_hit_ok;
                miss_pulse  <= |w_expire;
                wrong_pulse <= w_wrong;
            end
        end
    end
endmodule

// File: tb/tb_led_target_ctrl.sv
// tb_led_target_ctrl: directed table, corner sequences and random stimulus against a deadline-based game model.
module tb_led_target_ctrl;
    localparam int N     = 18;
    localparam int IW    = $clog2(N);
    localparam int MAXM  = 3;
`ifdef TARGET_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]    level = '0;
    logic          led_request = 1'b0, hit_valid = 1'b0;
    logic [IW-1:0] led_index = '0, hit_index = '0;
    logic [N-1:0]  leds;
    logic          hit_pulse, miss_pulse, wrong_pulse, game_over;
    logic [15:0]   score;
    logic [7:0]    misses;

    led_target_ctrl #(.LED_COUNT(N), .LIFE0(8), .LIFE1(4), .LIFE2(2), .MAX_MISSES(MAXM)) dut (
        .clk(clk), .rst(rst), .start(start), .level(level),
        .led_request(led_request), .led_index(led_index),
        .hit_valid(hit_valid), .hit_index(hit_index),
        .leds(leds), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse),
        .score(score), .misses(misses), .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int t = 0;
    int m_state, m_score, m_misses;
    int m_dl [N];
    bit m_hp, m_mp, m_wp, m_go;

    typedef struct {
        bit st; bit [1:0] lv; bit lr; int li; bit hv; int hi;
        logic [N-1:0] leds; int sc; int mi; logic [3:0] fl;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, t);
        end
    endtask

    function automatic int life(input bit [1:0] lv);
        return lv == 2'd1 ? 4 : lv == 2'd2 ? 2 : 8;
    endfunction

    function automatic logic [N-1:0] m_leds();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_dl[i] != 0;
        return v;
    endfunction

    task automatic m_reset();
        m_state = 0; m_score = 0; m_misses = 0;
        m_hp = 0; m_mp = 0; m_wp = 0; m_go = 0;
        foreach (m_dl[i]) m_dl[i] = 0;
    endtask

    // Each lit LED remembers the edge number at which it goes dark.
    task automatic m_edge(input bit st, input bit [1:0] lv, input bit lr, input int li, input bit hv, input int hi);
        int pre [N];
        bit hit_ok;
        int nexp;
        t++;
        m_hp = 0; m_mp = 0; m_wp = 0;
        if (st) begin
            m_state = 1; m_score = 0; m_misses = 0; m_go = 0;
            foreach (m_dl[i]) m_dl[i] = 0;
        end else if (m_state == 1 && m_misses >= MAXM) begin
            m_state = 2; m_go = 1;
            foreach (m_dl[i]) m_dl[i] = 0;
        end else if (m_state == 1) begin
            pre = m_dl;
            hit_ok = hv && hi < N && pre[hi] != 0;
            nexp = 0;
            for (int i = 0; i < N; i++)
                if (pre[i] == t && !(hit_ok && hi == i)) begin m_dl[i] = 0; nexp++; end
            if (hit_ok) begin
                m_dl[hi] = 0; m_hp = 1;
                if (m_score < 65535) m_score++;
            end
            m_wp = hv && !hit_ok;
            if (lr && li < N && pre[li] == 0) m_dl[li] = t + life(lv);
            m_misses = m_misses + nexp + (PEN != 0 && m_wp ? 1 : 0);
            if (m_misses > MAXM) m_misses = MAXM;
            m_mp = nexp > 0;
        end
    endtask

    task automatic cmp_model();
        chk("leds", 32'(leds), 32'(m_leds()));
        chk("score", 32'(score), 32'(m_score));
        chk("misses", 32'(misses), 32'(m_misses));
        chk("flags", 32'({hit_pulse, miss_pulse, wrong_pulse, game_over}), 32'({m_hp, m_mp, m_wp, m_go}));
    endtask

    task automatic drive(input bit st, input bit [1:0] lv, input bit lr, input int li, input bit hv, input int hi);
        start = st; level = lv; led_request = lr; led_index = IW'(li);
        hit_valid = hv; hit_index = IW'(hi);
        @(posedge clk);
        m_edge(st, lv, lr, li, hv, hi);
        @(negedge clk);
        start = 0; led_request = 0; hit_valid = 0;
        cmp_model();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic row(input bit st, input bit [1:0] lv, input bit lr, input int li, input bit hv, input int hi,
                       input logic [N-1:0] l, input int sc, input int mi, input logic [3:0] fl);
        vec_t v;
        v.st = st; v.lv = lv; v.lr = lr; v.li = li; v.hv = hv; v.hi = hi;
        v.leds = l; v.sc = sc; v.mi = mi; v.fl = fl;
        tbl.push_back(v);
    endtask

    initial begin
        int lit[$];
        int hi;
        m_reset();
        // flags column is {hit_pulse, miss_pulse, wrong_pulse, game_over}
        row(1, 0, 0, 0, 0, 0, 18'h0, 0, 0, 4'b0000);
        row(0, 0, 1, 5, 0, 0, 18'h20, 0, 0, 4'b0000);
        repeat (7) row(0, 0, 0, 0, 0, 0, 18'h20, 0, 0, 4'b0000);
        row(0, 0, 0, 0, 0, 0, 18'h0, 0, 1, 4'b0100);
        row(0, 0, 0, 0, 0, 0, 18'h0, 0, 1, 4'b0000);
        row(0, 1, 1, 3, 0, 0, 18'h8, 0, 1, 4'b0000);
        row(0, 0, 0, 0, 0, 0, 18'h8, 0, 1, 4'b0000);
        row(0, 0, 0, 0, 1, 3, 18'h0, 1, 1, 4'b1000);
        repeat (2) row(0, 0, 0, 0, 0, 0, 18'h0, 1, 1, 4'b0000);
        row(0, 0, 1, 18, 0, 0, 18'h0, 1, 1, 4'b0000);
        row(0, 0, 1, 17, 0, 0, 18'h20000, 1, 1, 4'b0000);
        row(0, 2, 1, 17, 0, 0, 18'h20000, 1, 1, 4'b0000);
        repeat (6) row(0, 0, 0, 0, 0, 0, 18'h20000, 1, 1, 4'b0000);
        row(0, 0, 0, 0, 0, 0, 18'h0, 1, 2, 4'b0100);
        row(0, 0, 0, 0, 1, 7, 18'h0, 1, 2 + PEN, 4'b0010);
        row(0, 0, 0, 0, 0, 0, 18'h0, 1, 2 + PEN, {3'b000, PEN != 0});

        repeat (2) @(negedge clk);
        chk("reset_leds", 32'(leds), 0);
        chk("reset_cnt", {score, misses, 8'(0)}, 0);
        chk("reset_flags", 32'({hit_pulse, miss_pulse, wrong_pulse, game_over}), 0);
        rst = 0;
        drive(0, 0, 1, 4, 0, 0);
        chk("idle_ignores_req", 32'(leds), 0);

        foreach (tbl[k]) begin
            drive(tbl[k].st, tbl[k].lv, tbl[k].lr, tbl[k].li, tbl[k].hv, tbl[k].hi);
            chk($sformatf("tbl%0d_leds", k), 32'(leds), 32'(tbl[k].leds));
            chk($sformatf("tbl%0d_score", k), 32'(score), 32'(tbl[k].sc));
            chk($sformatf("tbl%0d_misses", k), 32'(misses), 32'(tbl[k].mi));
            chk($sformatf("tbl%0d_flags", k), 32'({hit_pulse, miss_pulse, wrong_pulse, game_over}), 32'(tbl[k].fl));
        end

        // same-cycle hit and request on a lit LED; hit on the expiry cycle
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 2, 0, 0);
        drive(0, 0, 1, 2, 1, 2);
        chk("hitreq_leds", 32'(leds), 0);
        chk("hitreq_score", 32'(score), 1);
        drive(0, 2, 1, 4, 0, 0);
        idle();
        drive(0, 0, 0, 0, 1, 4);
        chk("hit_on_expiry_score", 32'(score), 2);
        chk("hit_on_expiry_misses", 32'(misses), 0);
        chk("hit_on_expiry_flags", 32'({hit_pulse, miss_pulse}), 32'(2'b10));

        // simultaneous expiries, then game over
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        idle();
        drive(0, 2, 1, 1, 0, 0);
        idle();
        idle();
        chk("dual_expiry_misses", 32'(misses), 2);
        chk("dual_expiry_pulse", 32'(miss_pulse), 1);
        drive(0, 2, 1, 2, 0, 0);
        idle();
        idle();
        chk("third_expiry_misses", 32'(misses), 3);
        chk("not_over_yet", 32'(game_over), 0);
        drive(0, 0, 1, 3, 0, 0);
        chk("over_flag", 32'(game_over), 1);
        chk("over_leds", 32'(leds), 0);
        drive(0, 0, 1, 3, 0, 0);
        chk("over_ignores_req", 32'(leds), 0);
        drive(0, 0, 0, 0, 1, 3);
        chk("over_no_wrong", 32'(wrong_pulse), 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("restart", {score, misses, 7'(0), game_over}, 0);

        // asynchronous reset mid-game
        drive(0, 0, 1, 9, 0, 0);
        drive(0, 0, 0, 0, 1, 9);
        drive(0, 0, 1, 9, 0, 0);
        #1 rst = 1;
        #1;
        chk("async_rst_leds", 32'(leds), 0);
        chk("async_rst_cnt", {score, misses, 8'(0)}, 0);
        chk("async_rst_flags", 32'({hit_pulse, miss_pulse, wrong_pulse, game_over}), 0);
        m_reset();
        @(negedge clk);
        rst = 0;
        drive(0, 0, 1, 9, 0, 0);
        chk("post_rst_idle", 32'(leds), 0);

        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            lit = {};
            for (int i = 0; i < N; i++) if (m_dl[i] != 0) lit.push_back(i);
            hi = (lit.size() > 0 && $urandom_range(0, 2) != 0) ? lit[$urandom_range(0, lit.size() - 1)]
                                                               : int'($urandom_range(0, 19));
            drive($urandom_range(0, 39) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                  int'($urandom_range(0, 19)), $urandom_range(0, 2) == 0, hi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/led_target_ctrl.md
# led_target_ctrl

Consumer side of the random-target request stream: accepts `led_index`/`led_request` pulses from the LFSR target generator. Lights the addressed LED for a level-dependent lifetime and resolves player hits against lit targets. Counts score and misses, and ends the game after a configurable number of misses. Sits between the target generator and the LED/7-segment display drivers.

## Interface
- `LED_COUNT`, 18, number of targets/LEDs
- `IDX_W`, `$clog2(LED_COUNT)`, index width
- `LIFE0`, 50_000_000, lit lifetime in cycles at level 0
- `LIFE1`, 20_000_000, lit lifetime at level 1
- `LIFE2`, 10_000_000, lit lifetime at level 2 (level 3 uses `LIFE0`)
- `MAX_MISSES`, 5, miss count that ends the game (1..255)
- `clk` in 1 system clock
- `rst` in 1 asynchronous, active-high reset
- `start` in 1 one-cycle pulse; starts or restarts a game
- `level` in 2 difficulty; sampled when a target is lit
- `led_request` in 1 one-cycle pulse, target request
- `led_index` in IDX_W target index, valid with `led_request`
- `hit_valid` in 1 one-cycle pulse, player strike
- `hit_index` in IDX_W struck index, valid with `hit_valid`
- `leds` out LED_COUNT lit-target vector
- `hit_pulse` out 1 one cycle per scored hit
- `miss_pulse` out 1 one cycle when ≥1 target expired
- `wrong_pulse` out 1 one cycle per hit on an unlit or out-of-range index
- `score` out 16 scored hits, saturating at 0xFFFF
- `misses` out 8 expiries (plus penalties), saturating at `MAX_MISSES`
- `game_over` out 1 high in OVER state

## Operation
- State machine:
  - IDLE: reset state; requests and hits ignored.
  - On `start`: go to RUN.
  - RUN: on `misses` ≥ `MAX_MISSES` after an update, go to OVER.
  - OVER: on `start`, go to RUN.
  - `start` in any state clears `leds`, `score`, `misses` and all lifetimes, then enters RUN. Stimulus arriving in the same cycle as `start` is ignored.
- Each LED has its own down-counter, 32-bit minimum.
- Request in RUN:
  - `led_index` ≥ `LED_COUNT`: dropped.
  - LED already lit: dropped; the remaining lifetime is unchanged.
  - LED unlit: bit set; counter loaded with `LIFEn` for the current `level`.
- Lifetime:
  - A lit counter decrements every cycle.
  - When the counter equals 1, the bit clears at that edge. The LED is therefore lit for exactly `LIFEn` cycles.
  - Each expiry adds 1 to `misses`. Simultaneous expiries add their count, saturating.
  - `miss_pulse` asserts once if any LED expired that cycle.
- Hit in RUN:
  - Evaluated against the pre-edge `leds`.
  - If lit: clear the bit, `score`+1, `hit_pulse`.
  - Otherwise: `wrong_pulse`, and `score` is unchanged.
- Simultaneous events, same index:
  - Hit on a lit LED plus a request: the hit scores and the request is dropped; the LED ends unlit.
  - Hit on an unlit LED plus a request: wrong hit, and the request lights the LED.
  - Hit plus expiry in the same cycle: the hit wins; scored, no miss.
- Entering OVER clears `leds` and all counters. In OVER, requests and hits are ignored and pulses stay low.
- `rst` at any time returns to IDLE immediately:
  - `leds`=0, `score`=0, `misses`=0
  - all pulses 0, `game_over`=0

## Timing
- All outputs are registered.
- Request at edge N: `leds` bit visible after edge N.
- Hit at edge N: `leds`, `score` and `hit_pulse`/`wrong_pulse` update at edge N.
- An expiring miss updates `misses` and `miss_pulse` at the same edge as the bit clears.
- `game_over` asserts one edge after `misses` reaches `MAX_MISSES`, and `leds` clears on that same edge.
- Pulses last exactly one cycle. One request and one hit are accepted per cycle.

## Configuration
- `TARGET_PENALTY_EN`:
  - Defined: each `wrong_pulse` also adds 1 to `misses`, saturating. A wrong hit can trigger OVER.
  - Undefined: a wrong hit only pulses `wrong_pulse`.

## Test plan
All scenarios use `LIFE0`=8, `LIFE1`=4, `LIFE2`=2, `MAX_MISSES`=3.
- Reset then `start`; request idx 5 at level 0 → `leds`=0x00020 for exactly 8 cycles, then clears; `miss_pulse` for one cycle; `misses`=1.
- Request idx 3 at level 1; hit idx 3 two cycles later → bit clears, `score`=1, `hit_pulse` once, no miss afterwards.
- Hit idx 7 while unlit → `wrong_pulse`, `score`=0.
  - `misses`=0 without the macro; `misses`=1 with `TARGET_PENALTY_EN`.
- Request idx 17 then idx 18 → only bit 17 is set; a request on an already-lit idx 17 does not extend its 8-cycle life.
- Same-cycle hit and request on lit idx 2 → `score`+1, LED ends unlit. Hit landing in an LED's expiry cycle → scored, `misses` unchanged.
- Three expiries → `misses`=3, `game_over`=1 next cycle, `leds`=0, requests ignored. `start` → `score`=0, `misses`=0, `game_over`=0. `rst` mid-game → all outputs zero immediately.
